// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared multi-cycle ALU
//
// Purpose: accepts one operation at a time from requester A or B (round-robin
// when both are pending), executes it on a single ALU datapath and holds the
// result until the consumer takes it.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   i_reqA_valid / i_reqB_valid     requester has an operation pending
//   o_reqA_ready / o_reqB_ready     operation accepted this cycle (combinational)
//   i_reqA_op1/op2, i_reqB_op1/op2  32-bit operands
//   i_reqA_sel / i_reqB_sel         4-bit ALU operation select
//   o_rsp_valid / i_rsp_ready       result handshake
//   o_rsp_id                        result owner (0 = A, 1 = B)
//   o_rsp_data, o_rsp_zflag         result and result-is-zero flag
//   o_busy                          operation in flight (EXEC or RESP)
module alu_arbiter #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_reqA_valid,
  input  logic        i_reqB_valid,
  output logic        o_reqA_ready,
  output logic        o_reqB_ready,
  input  logic [31:0] i_reqA_op1,
  input  logic [31:0] i_reqA_op2,
  input  logic [31:0] i_reqB_op1,
  input  logic [31:0] i_reqB_op2,
  input  logic [3:0]  i_reqA_sel,
  input  logic [3:0]  i_reqB_sel,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_zflag,
  output logic        o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  // Counter reload for a multiply: EXEC lasts until the counter reaches zero.
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  logic [1:0]  state;
  logic        last_b;      // 1 when B was the most recent grant
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [3:0]  sel_q;
  logic        id_q;
  logic [3:0]  cnt;

  logic        grant_b;
  logic        in_idle;
  logic        accept;
  logic [3:0]  req_sel;
  logic [31:0] alu_res;

  // Contention goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant_b = 1'b0;
    if (i_reqA_valid && i_reqB_valid) begin
      grant_b = ~last_b;
    end else begin
      grant_b = i_reqB_valid;
    end
  end

  // Gating with reset keeps both readies low for the whole reset window.
  assign in_idle      = (state == S_IDLE) && !reset;
  assign o_reqA_ready = in_idle && i_reqA_valid && !grant_b;
  assign o_reqB_ready = in_idle && i_reqB_valid && grant_b;
  assign accept       = o_reqA_ready || o_reqB_ready;
  assign req_sel      = grant_b ? i_reqB_sel : i_reqA_sel;
  assign o_busy       = (state != S_IDLE);

  // Shared datapath works only on latched operands so request ports may change freely.
  always_comb begin
    alu_res = 32'h0;
    case (sel_q)
      OP_AND:  alu_res = op1_q & op2_q;
      OP_OR:   alu_res = op1_q | op2_q;
      OP_ADD:  alu_res = op1_q + op2_q;
      OP_SUB:  alu_res = op1_q - op2_q;
      OP_SLT:  alu_res = {31'b0, (op1_q < op2_q)};
      OP_MUL:  alu_res = op1_q * op2_q;
      default: alu_res = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last_b      <= 1'b1;
      op1_q       <= 32'h0;
      op2_q       <= 32'h0;
      sel_q       <= 4'h0;
      id_q        <= 1'b0;
      cnt         <= 4'h0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= 1'b0;
      o_rsp_data  <= 32'h0;
      o_rsp_zflag <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op1_q  <= grant_b ? i_reqB_op1 : i_reqA_op1;
            op2_q  <= grant_b ? i_reqB_op2 : i_reqA_op2;
            sel_q  <= req_sel;
            id_q   <= grant_b;
            last_b <= grant_b;
            cnt    <= (req_sel == OP_MUL) ? MUL_CNT : 4'h0;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == 4'h0) begin
            o_rsp_data  <= alu_res;
            o_rsp_zflag <= (alu_res == 32'h0);
            o_rsp_id    <= id_q;
            state       <= S_RESP;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        S_RESP: begin
          // Valid rises one cycle after the result registers, then holds until taken.
          if (!o_rsp_valid) begin
            o_rsp_valid <= 1'b1;
          end else if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_reqA_valid, i_reqB_valid;
  logic        o_reqA_ready, o_reqB_ready;
  logic [31:0] i_reqA_op1, i_reqA_op2, i_reqB_op1, i_reqB_op2;
  logic [3:0]  i_reqA_sel, i_reqB_sel;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_zflag, o_busy;
  logic [31:0] o_rsp_data;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int seen;

  alu_arbiter #(.MUL_LAT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_reqA_valid (i_reqA_valid),
    .i_reqB_valid (i_reqB_valid),
    .o_reqA_ready (o_reqA_ready),
    .o_reqB_ready (o_reqB_ready),
    .i_reqA_op1   (i_reqA_op1),
    .i_reqA_op2   (i_reqA_op2),
    .i_reqB_op1   (i_reqB_op1),
    .i_reqB_op2   (i_reqB_op2),
    .i_reqA_sel   (i_reqA_sel),
    .i_reqB_sel   (i_reqB_sel),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_zflag  (o_rsp_zflag),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller drives request inputs first; this checks the grant, latency, result,
  // optional back-pressure stall, and the return to idle.
  task automatic txn(input string tag, input logic exp_b, input logic [31:0] exp_data,
                     input int exp_lat, input int stall);
    int lat;
    logic [31:0] a1, b1;
    logic [3:0]  as, bs;
    #1;
    chk1({tag, "_rdyA"}, o_reqA_ready, !exp_b);
    chk1({tag, "_rdyB"}, o_reqB_ready, exp_b);
    a1 = i_reqA_op1; b1 = i_reqB_op1; as = i_reqA_sel; bs = i_reqB_sel;
    tick();
    // Disturb request ports after accept; the in-flight result must not change.
    i_reqA_op1 = a1 ^ 32'hDEAD_BEEF;
    i_reqB_op1 = b1 ^ 32'h1234_5678;
    i_reqA_sel = as ^ 4'h5;
    i_reqB_sel = bs ^ 4'h5;
    chk1({tag, "_busy"}, o_busy, 1'b1);
    lat = 0;
    while (o_rsp_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    chk32({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk1({tag, "_id"}, o_rsp_id, exp_b);
    chk32({tag, "_data"}, o_rsp_data, exp_data);
    chk1({tag, "_zflag"}, o_rsp_zflag, exp_data == 32'h0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk1({tag, "_stall_valid"}, o_rsp_valid, 1'b1);
      chk32({tag, "_stall_data"}, o_rsp_data, exp_data);
      chk1({tag, "_stall_id"}, o_rsp_id, exp_b);
      chk1({tag, "_stall_rdyA"}, o_reqA_ready, 1'b0);
      chk1({tag, "_stall_rdyB"}, o_reqB_ready, 1'b0);
      chk1({tag, "_stall_busy"}, o_busy, 1'b1);
    end
    i_reqA_op1 = a1; i_reqB_op1 = b1; i_reqA_sel = as; i_reqB_sel = bs;
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk1({tag, "_idle_busy"}, o_busy, 1'b0);
    chk1({tag, "_idle_valid"}, o_rsp_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    i_reqA_valid = 1'b1;
    i_reqB_valid = 1'b0;
    i_reqA_op1 = 32'h0; i_reqA_op2 = 32'h0; i_reqA_sel = 4'h0;
    i_reqB_op1 = 32'h0; i_reqB_op2 = 32'h0; i_reqB_sel = 4'h0;
    i_rsp_ready = 1'b0;
    tick();
    tick();
    chk1("rst_valid", o_rsp_valid, 1'b0);
    chk1("rst_id", o_rsp_id, 1'b0);
    chk32("rst_data", o_rsp_data, 32'h0);
    chk1("rst_zflag", o_rsp_zflag, 1'b1);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_rdyA", o_reqA_ready, 1'b0);
    reset = 1'b0;

    // Both held valid: grants alternate starting with A.
    i_reqA_valid = 1'b1; i_reqB_valid = 1'b1;
    i_reqA_op1 = 32'hFF00_FF00; i_reqA_op2 = 32'h0FF0_0FF0; i_reqA_sel = 4'b0000;
    i_reqB_op1 = 32'd3;         i_reqB_op2 = 32'd3;         i_reqB_sel = 4'b0110;
    txn("rr1_A", 1'b0, 32'h0F00_0F00, 2, 0);
    txn("rr2_B", 1'b1, 32'h0, 2, 0);
    txn("rr3_A", 1'b0, 32'h0F00_0F00, 2, 0);
    txn("rr4_B", 1'b1, 32'h0, 2, 0);

    // Lone A, granted back-to-back.
    i_reqB_valid = 1'b0;
    i_reqA_op1 = 32'd7; i_reqA_op2 = 32'd5; i_reqA_sel = 4'b0010;
    txn("a_add", 1'b0, 32'd12, 2, 0);
    i_reqA_op1 = 32'h0000_00F0; i_reqA_op2 = 32'h0000_000F; i_reqA_sel = 4'b0001;
    txn("a_or", 1'b0, 32'h0000_00FF, 2, 0);
    i_reqA_op1 = 32'h0001_0000; i_reqA_op2 = 32'h0001_0000; i_reqA_sel = 4'b0011;
    txn("a_mul_wrap", 1'b0, 32'h0, 4, 0);
    i_reqA_op1 = 32'd3; i_reqA_op2 = 32'd5; i_reqA_sel = 4'b0011;
    txn("a_mul", 1'b0, 32'd15, 4, 0);

    // Both valid, last grant A -> B; unsigned compare with 5-cycle back-pressure.
    i_reqB_valid = 1'b1;
    i_reqB_op1 = 32'hFFFF_FFFF; i_reqB_op2 = 32'd1; i_reqB_sel = 4'b0111;
    txn("b_slt_stall", 1'b1, 32'h0, 2, 5);
    chk1("next_accept_rdyA", o_reqA_ready, 1'b1);
    i_reqA_valid = 1'b0;
    i_reqB_op1 = 32'd1; i_reqB_op2 = 32'd2; i_reqB_sel = 4'b0111;
    txn("b_slt_true", 1'b1, 32'd1, 2, 0);
    i_reqB_op1 = 32'd5; i_reqB_op2 = 32'd5; i_reqB_sel = 4'b0101;
    txn("b_bad_sel", 1'b1, 32'h0, 2, 0);
    i_reqB_op1 = 32'd1; i_reqB_op2 = 32'd2; i_reqB_sel = 4'b0110;
    txn("b_sub_wrap", 1'b1, 32'hFFFF_FFFF, 2, 0);

    // Reset in the middle of a multiply.
    i_reqB_valid = 1'b0;
    i_reqA_valid = 1'b1;
    i_reqA_op1 = 32'd3; i_reqA_op2 = 32'd5; i_reqA_sel = 4'b0011;
    tick();
    i_reqA_valid = 1'b0;
    chk1("mrst_busy_pre", o_busy, 1'b1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk1("mrst_valid", o_rsp_valid, 1'b0);
    chk1("mrst_busy", o_busy, 1'b0);
    chk32("mrst_data", o_rsp_data, 32'h0);
    chk1("mrst_zflag", o_rsp_zflag, 1'b1);
    chk1("mrst_id", o_rsp_id, 1'b0);
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (o_rsp_valid === 1'b1) seen++;
    end
    chk32("mrst_no_rsp", 32'(seen), 32'd0);

    i_reqA_valid = 1'b1; i_reqB_valid = 1'b1;
    i_reqA_op1 = 32'hFF00_FF00; i_reqA_op2 = 32'h0FF0_0FF0; i_reqA_sel = 4'b0000;
    i_reqB_op1 = 32'd3;         i_reqB_op2 = 32'd3;         i_reqB_sel = 4'b0110;
    txn("post_rst_A", 1'b0, 32'h0F00_0F00, 2, 0);
    i_reqA_valid = 1'b0; i_reqB_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, EXEC cycles spent on a multiply (legal 1..8).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports i_reqA_valid / i_reqB_valid  input  1  requester A/B has an operation pending.
REQ-005 SHALL have ports o_reqA_ready / o_reqB_ready  output  1  requester A/B operation accepted this cycle.
REQ-006 SHALL have ports i_reqA_op1, i_reqA_op2, i_reqB_op1, i_reqB_op2  input  32  operands.
REQ-007 SHALL have ports i_reqA_sel / i_reqB_sel  input  4  ALU operation select.
REQ-008 SHALL have port o_rsp_valid  output  1  result available.
REQ-009 SHALL have port i_rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port o_rsp_id  output  1  result owner (0 = A, 1 = B).
REQ-011 SHALL have port o_rsp_data  output  32  result.
REQ-012 SHALL have port o_rsp_zflag  output  1  result equals zero.
REQ-013 SHALL have port o_busy  output  1  high in EXEC or RESP.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one shared ALU datapath.
REQ-015 In IDLE, SHALL grant one requester: sole valid requester wins; both valid -> requester not granted last wins.
REQ-016 Ready SHALL be combinational: high only in IDLE, only for the granted requester, only while its valid is high; never both high.
REQ-017 On accept (valid & ready), SHALL latch op1, op2, sel, id, update last-grant pointer, enter EXEC.
REQ-018 Ops: 0000 AND; 0001 OR; 0010 ADD mod 2^32; 0110 SUB mod 2^32; 0111 unsigned op1<op2 -> 1 else 0; 0011 MUL low 32 bits.
REQ-019 Any other sel SHALL yield data 0, zflag 1, with no error signal.
REQ-020 EXEC SHALL last 1 cycle for non-multiply ops and MUL_LAT cycles for 0011, using a down-counter.
REQ-021 Result, zflag (data == 32'h0) and id SHALL be registered on the final EXEC cycle; o_rsp_valid rises next cycle (RESP).
REQ-022 Non-multiply latency: accept at edge N -> o_rsp_valid high after edge N+2.
REQ-023 In RESP, o_rsp_valid, o_rsp_id, o_rsp_data and o_rsp_zflag SHALL hold stable until i_rsp_ready is high at a rising edge; then return to IDLE.
REQ-024 No new request SHALL be accepted on the RESP-exit cycle; earliest next accept is the following cycle.
REQ-025 Requester valid dropping in EXEC/RESP SHALL NOT affect the in-flight operation.
REQ-026 Operand/select changes on request ports after accept SHALL NOT affect the result.
REQ-027 Pointer SHALL change only on accept; a lone requester may be granted back-to-back.

Reset
REQ-028 Reset SHALL force IDLE immediately, independent of clk.
REQ-029 Reset values: o_rsp_valid 0, o_rsp_id 0, o_rsp_data 0, o_rsp_zflag 1, o_busy 0, ready outputs 0 while reset is high.
REQ-030 Reset SHALL set the last-grant pointer so A wins the first simultaneous request.
REQ-031 Reset mid-EXEC or mid-RESP SHALL discard the operation with no response.

Verification
REQ-032 A alone: op1=7, op2=5, sel=0010 -> o_reqA_ready 1 same cycle; 2 cycles later rsp_valid=1, id=0, data=12, zflag=0.
REQ-033 A and B held valid together, 4 transactions -> grants A,B,A,B; B op1=3, op2=3, sel=0110 -> data=0, zflag=1.
REQ-034 MUL_LAT=3, op1=32'h0001_0000, op2=32'h0001_0000, sel=0011 -> rsp_valid 4 cycles after accept, data=0, zflag=1.
REQ-035 i_rsp_ready held low 5 cycles -> outputs stable, both ready 0, o_busy 1; ready high -> IDLE next cycle.
REQ-036 Reset asserted during MUL EXEC -> outputs at reset values immediately, no rsp_valid after release; next simultaneous request granted to A.
REQ-037 sel=0111, op1=32'hFFFF_FFFF, op2=1 -> data=0, zflag=1 (unsigned compare); sel=0101 -> data=0, zflag=1.
